// File: rtl/mp_add_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder.
package mp_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // A single-limb operand still needs a 1-bit index register.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/mp_add_sequencer_add8_slice.sv
// One 8-bit adder slice with carry in/out; combinational, shared by every byte step.
module add8_slice
    import mp_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/mp_add_sequencer.sv
// Byte-serial wide adder, LSB first; out_valid rises NBYTES cycles after accept, holds until out_ready.
// No accept while RUN/DONE. Optional subtract mode under MP_ADD_SUB_EN (adds op input).
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     c_in,
`ifdef MP_ADD_SUB_EN
    input  logic                     op,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     c_out,
    output logic                     busy
);

    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    typedef logic [NBYTES-1:0][BYTE_W-1:0] limbs_t;

    state_t           state_q, state_d;
    limbs_t           a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDX_W-1:0] idx_q, idx_d;
`ifdef MP_ADD_SUB_EN
    logic             op_q, op_d;
`endif

    logic [BYTE_W-1:0] slice_a, slice_b, slice_sum;
    logic              slice_cout;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i];
                slice_b = b_q[i];
            end
        end
`ifdef MP_ADD_SUB_EN
        if (op_q) slice_b = ~slice_b;
`endif
    end

    add8_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef MP_ADD_SUB_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
`ifdef MP_ADD_SUB_EN
                    op_d    = op;
                    if (op) carry_d = 1'b1;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[i] = slice_sum;
                end
                carry_d = slice_cout;
                // Index parks on the last limb rather than wrapping.
                if (idx_q == LAST) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef MP_ADD_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef MP_ADD_SUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign c_out     = cout_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer: three instances (NBYTES = 1, 4, 16) sharing stimulus, one active at a time.
module tb_mp_add_sequencer;

`ifdef MP_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         riv, ror, rci, rop;
    logic [127:0] ra, rb;
    int           sel;

    logic         iv1, iv4, iv16;
    logic         ir1, ir4, ir16, ov1, ov4, ov16, co1, co4, co16, bz1, bz4, bz16;
    logic [7:0]   s1;
    logic [31:0]  s4;
    logic [127:0] s16;

    logic         cur_ir, cur_ov, cur_co, cur_bz;
    logic [127:0] cur_sum;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    assign iv1  = riv && (sel == 1);
    assign iv4  = riv && (sel == 4);
    assign iv16 = riv && (sel == 16);

    mp_add_sequencer #(.NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(ra[7:0]), .b(rb[7:0]), .c_in(rci),
`ifdef MP_ADD_SUB_EN
        .op(rop),
`endif
        .out_valid(ov1), .out_ready(ror), .sum(s1), .c_out(co1), .busy(bz1));

    mp_add_sequencer #(.NBYTES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(ra[31:0]), .b(rb[31:0]), .c_in(rci),
`ifdef MP_ADD_SUB_EN
        .op(rop),
`endif
        .out_valid(ov4), .out_ready(ror), .sum(s4), .c_out(co4), .busy(bz4));

    mp_add_sequencer #(.NBYTES(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(ra), .b(rb), .c_in(rci),
`ifdef MP_ADD_SUB_EN
        .op(rop),
`endif
        .out_valid(ov16), .out_ready(ror), .sum(s16), .c_out(co16), .busy(bz16));

    always_comb begin
        cur_ir = ir4; cur_ov = ov4; cur_co = co4; cur_bz = bz4; cur_sum = 128'(s4);
        case (sel)
            1:  begin cur_ir = ir1;  cur_ov = ov1;  cur_co = co1;  cur_bz = bz1;  cur_sum = 128'(s1); end
            16: begin cur_ir = ir16; cur_ov = ov16; cur_co = co16; cur_bz = bz16; cur_sum = s16;      end
            default: ;
        endcase
    end

    // Reference: plain wide arithmetic, returns {c_out, sum zero-padded to 128 bits}.
    function automatic logic [128:0] model(input int n, input logic [127:0] a_v, b_v,
                                           input logic ci_v, op_v);
        logic [128:0] mask, full;
        mask = (129'd1 << (8 * n)) - 129'd1;
        if (op_v) full = {1'b0, a_v} + ({1'b0, ~b_v} & mask) + 129'd1;
        else      full = {1'b0, a_v} + {1'b0, b_v} + 129'(ci_v);
        return {full[8 * n], 128'(full & mask)};
    endfunction

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand set on the selected instance, then wait for out_valid and check latency/result.
    task automatic op_run(input string tag, input logic [127:0] a_v, b_v, input logic ci_v, op_v,
                          input logic [128:0] exp);
        int cnt;
        ra = a_v; rb = b_v; rci = ci_v; rop = op_v; riv = 1'b1;
        tick();
        riv = 1'b0;
        cnt = 0;
        while (!cur_ov && cnt < 200) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 136'(cnt), 136'(sel));
        check({tag, "_result"}, 136'({cur_co, cur_sum}), 136'(exp));
    endtask

    task automatic rand_op(input int n);
        logic [127:0] mask, a_v, b_v;
        logic         ci_v, op_v;
        int           k;
        mask = (n == 16) ? {128{1'b1}} : ((128'd1 << (8 * n)) - 128'd1);
        a_v  = {$urandom, $urandom, $urandom, $urandom} & mask;
        b_v  = {$urandom, $urandom, $urandom, $urandom} & mask;
        ci_v = 1'($urandom);
        op_v = SUB_EN ? 1'($urandom) : 1'b0;
        ror  = 1'b0;
        op_run($sformatf("rand%0d", n), a_v, b_v, ci_v, op_v, model(n, a_v, b_v, ci_v, op_v));
        k = $urandom_range(0, 3);
        repeat (k) tick();
        ror = 1'b1;
        tick();
        ror = 1'b0;
        if ($urandom_range(0, 1) == 1) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [128:0] exp;
        logic         seen;
        sel = 4; rst = 1'b1; riv = 1'b0; ror = 1'b1; rci = 1'b0; rop = 1'b0; ra = '0; rb = '0;
        repeat (2) tick();
        check("rst_in_ready", 136'(cur_ir), 136'(1));
        check("rst_out_valid", 136'(cur_ov), 136'(0));
        check("rst_busy", 136'(cur_bz), 136'(0));
        check("rst_sum", 136'(cur_sum), 136'(0));
        check("rst_c_out", 136'(cur_co), 136'(0));
        rst = 1'b0;

        op_run("wrap", 128'hFFFF_FFFF, 128'h1, 1'b0, 1'b0, {1'b1, 128'h0});
        tick();
        check("wrap_pulse", 136'(cur_ov), 136'(0));
        check("wrap_in_ready", 136'(cur_ir), 136'(1));

        op_run("cin", 128'h1234_5678, 128'h1111_1111, 1'b1, 1'b0, {1'b0, 128'h2345_678A});
        tick();

        // Backpressure: result must hold while out_ready is low, and new offers are refused.
        ror = 1'b0;
        exp = model(4, 128'h89AB_CDEF, 128'h7654_3210, 1'b1, 1'b0);
        op_run("bp", 128'h89AB_CDEF, 128'h7654_3210, 1'b1, 1'b0, exp);
        riv = 1'b1; ra = 128'h5; rb = 128'h6;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), 136'(cur_ov), 136'(1));
            check($sformatf("bp_hold_result%0d", i), 136'({cur_co, cur_sum}), 136'(exp));
            check($sformatf("bp_in_ready%0d", i), 136'(cur_ir), 136'(0));
        end
        riv = 1'b0; ror = 1'b1;
        tick();
        check("bp_release_valid", 136'(cur_ov), 136'(0));
        check("bp_release_ready", 136'(cur_ir), 136'(1));
        check("bp_release_busy", 136'(cur_bz), 136'(0));

        // Reset while the third limb is being processed.
        ra = 128'hDEAD_BEEF; rb = 128'hCAFE_F00D; rci = 1'b1; riv = 1'b1;
        tick();
        riv = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 136'(cur_ir), 136'(1));
        check("mid_rst_busy", 136'(cur_bz), 136'(0));
        check("mid_rst_sum", 136'(cur_sum), 136'(0));
        check("mid_rst_c_out", 136'(cur_co), 136'(0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cur_ov) seen = 1'b1;
        end
        check("mid_rst_no_valid", 136'(seen), 136'(0));
        op_run("post_rst", 128'hA5A5_5A5A, 128'h5A5A_A5A5, 1'b1, 1'b0,
               model(4, 128'hA5A5_5A5A, 128'h5A5A_A5A5, 1'b1, 1'b0));
        tick();

        ra = 128'h1; rb = 128'h2; riv = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; riv = 1'b0;
        check("rst_vs_valid_busy", 136'(cur_bz), 136'(0));
        check("rst_vs_valid_ready", 136'(cur_ir), 136'(1));

`ifdef MP_ADD_SUB_EN
        op_run("sub_borrow", 128'h0, 128'h1, 1'b1, 1'b1, {1'b0, 128'hFFFF_FFFF});
        tick();
        op_run("sub_noborrow", 128'h5, 128'h3, 1'b0, 1'b1, {1'b1, 128'h2});
        tick();
`endif

        sel = 1;
        for (int i = 0; i < 1000; i++) rand_op(1);
        sel = 16;
        for (int i = 0; i < 1000; i++) rand_op(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
